// File: rtl/microwave_pkg.sv
// Shared keypad types: debounce FSM states, key width, one-hot test and key-to-BCD mapping.
// Pure declarations, no latency; no flow control involved.
package microwave_pkg;

   localparam int KEY_W = 10;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      DEB_RELEASE = 2'd3
   } kd_state_t;

   function automatic logic is_onehot(input logic [KEY_W-1:0] v);
      return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
   endfunction

   // bit9 is key 1 down to bit1 key 9; bit0 (key 0) falls through to 0
   function automatic logic [3:0] key_digit(input logic [KEY_W-1:0] v);
      logic [3:0] d;
      d = 4'd0;
      for (int i = 1; i < KEY_W; i++) begin
         if (v[i]) d = 4'(KEY_W - i);
      end
      return d;
   endfunction

endpackage

// File: rtl/keypad_debounce_if.sv
// Debounced key event bundle from the debouncer to the digit encoder.
// Registered signals, single-cycle key_valid strobe; no backpressure, consumer must accept every strobe.
interface keypad_debounce_if;
   import microwave_pkg::*;

   logic [KEY_W-1:0] keypad_clean;
   logic             key_valid;
   logic [3:0]       key_code;
   logic             busy;

   modport master (
      output keypad_clean,
      output key_valid,
      output key_code,
      output busy
   );

   modport slave (
      input keypad_clean,
      input key_valid,
      input key_code,
      input busy
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Latency 2 clock cycles; no backpressure.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             clrn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;

   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         meta_q <= '0;
         q      <= '0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/keypad_debounce.sv
// Keypad debouncer: synchronizes raw contacts, qualifies single-key presses/releases, strobes the BCD digit.
// Strobe DEBOUNCE_CYCLES+3 edges after a stable press; no backpressure, locked out while enablen=0.
module keypad_debounce
   import microwave_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8
) (
   input  logic             clock,
   input  logic             clrn,
   input  logic [KEY_W-1:0] keypad_raw,
   input  logic             enablen,
   keypad_debounce_if.master kb
);

   logic [KEY_W-1:0] keypad_s;
   kd_state_t        state_q, state_d;
   logic [KEY_W-1:0] cap_q, cap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [KEY_W-1:0] clean_q, clean_d;
   logic             valid_q, valid_d;
   logic [3:0]       code_q, code_d;
   logic             busy_q, busy_d;
   logic             armed_q, armed_d;
   logic             cnt_last;

   sync_2ff #(.WIDTH(KEY_W)) u_sync (
      .clock (clock),
      .clrn  (clrn),
      .d     (keypad_raw),
      .q     (keypad_s)
   );

   assign cnt_last = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cap_d    = cap_q;
      cnt_d    = cnt_q;
      valid_d  = 1'b0;
      code_d   = code_q;
      // A key first seen during lockout must be released before it may qualify
      armed_d  = armed_q;
      if (keypad_s == '0)  armed_d = 1'b1;
      else if (!enablen)   armed_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (enablen && armed_q && is_onehot(keypad_s)) begin
               cap_d   = keypad_s;
               cnt_d   = '0;
               state_d = DEB_PRESS;
            end
         end
         DEB_PRESS: begin
            if (!enablen) begin
               state_d = PRESSED;
            end else if (keypad_s != cap_q) begin
               state_d = IDLE;
            end else if (cnt_last) begin
               state_d = PRESSED;
               valid_d = 1'b1;
               code_d  = key_digit(cap_q);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (keypad_s == '0) begin
               cnt_d   = '0;
               state_d = DEB_RELEASE;
            end
         end
         DEB_RELEASE: begin
            if (keypad_s != '0) begin
               state_d = PRESSED;
            end else if (cnt_last) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      clean_d = (state_d == PRESSED || state_d == DEB_RELEASE) ? cap_d : '0;
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         cap_q   <= '0;
         cnt_q   <= '0;
         clean_q <= '0;
         valid_q <= 1'b0;
         code_q  <= 4'd0;
         busy_q  <= 1'b0;
         armed_q <= 1'b1;
      end else begin
         cap_q   <= cap_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         valid_q <= valid_d;
         code_q  <= code_d;
         busy_q  <= busy_d;
         armed_q <= armed_d;
      end
   end

   assign kb.keypad_clean = clean_q;
   assign kb.key_valid    = valid_q;
   assign kb.key_code     = code_q;
   assign kb.busy         = busy_q;

endmodule
